freq_sweep_ctrl: RTL and testbench
==================================

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 Parameter NUM_STEPS, default 11: number of frequency steps; pos 0 is the fastest (167 MHz), NUM_STEPS-1 the slowest (70 MHz).
REQ-002 Parameter DEFAULT_POS, default 7: pos after reset (100 MHz).
REQ-003 Parameter DONE_TIMEOUT, default 1000: cycles allowed for pll_reconfig to drop busy.
REQ-004 clk  in  1  system clock (50 MHz board clock).
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 btn_up, btn_down, btn_auto  in  1 each  debounced level inputs; each acts on its rising edge only.
REQ-007 start_auto  in  1  level input; while high it forces an auto sweep from pos 0.
REQ-008 passcount, failcount  in  32 each  counters from the memory tester.
REQ-009 pll_busy  in  1  busy output of pll_reconfig.
REQ-010 pos  out  4  current frequency step index; selects the ROM and the displayed frequency.
REQ-011 auto_o  out  1  auto-sweep mode is active.
REQ-012 recfg  out  1  reconfiguration in progress; high whenever state is not IDLE.
REQ-013 write_from_rom, reconfig, reconfig_reset  out  1 each  single-cycle pulses to pll_reconfig.

Function
REQ-014 Edge detection SHALL register each button input; an event is the cycle where the registered value is 0 and the current value is 1.
REQ-015 The FSM SHALL have the states IDLE, LOAD, SETTLE, WAIT_BUSY, WAIT_DONE.
REQ-016 The FSM SHALL accept a request only in IDLE; button edges and the auto-advance condition arising in any other state SHALL be discarded.
REQ-017 Request priority within one cycle, highest first: start_auto, btn_auto edge, btn_up edge, btn_down edge, auto-advance.
REQ-018 start_auto: pos<=0, auto_o<=1, request a reconfiguration.
REQ-019 btn_auto edge with auto_o=0: pos<=0, auto_o<=1, request. With auto_o=1: auto_o<=0, pos unchanged, request.
REQ-020 btn_up edge with pos>0: pos<=pos-1, auto_o<=0, request. At pos=0 the edge SHALL be ignored entirely.
REQ-021 btn_down edge with pos<NUM_STEPS-1: pos<=pos+1, auto_o<=0, request. At pos=NUM_STEPS-1 the edge SHALL be ignored entirely.
REQ-022 Auto-advance: when auto_o=1, passcount!=0, failcount!=0 and pos<NUM_STEPS-1: pos<=pos+1, request. At the last step the sweep SHALL stop with auto_o held at 1.
REQ-023 Request: IDLE->LOAD; recfg rises the cycle after the request.
REQ-024 LOAD: assert write_from_rom for exactly 1 cycle, then go to SETTLE.
REQ-025 SETTLE: wait exactly 1 cycle, then go to WAIT_BUSY.
REQ-026 WAIT_BUSY: stay while pll_busy=1. When pll_busy=0: pulse reconfig for 1 cycle, load the timeout counter with DONE_TIMEOUT, go to WAIT_DONE.
REQ-027 WAIT_DONE: the first cycle SHALL ignore pll_busy; the counter SHALL decrement every cycle.
REQ-028 WAIT_DONE exit: from the second cycle on, pll_busy=0 SHALL return the FSM to IDLE.
REQ-029 WAIT_DONE timeout: when the counter equals 1 and pll_busy=1, pulse reconfig_reset for 1 cycle and return to IDLE.
REQ-030 Timeout counter width SHALL be ceil(log2(DONE_TIMEOUT+1)) bits; it SHALL never underflow.
REQ-031 pos SHALL never leave the range 0..NUM_STEPS-1.

Reset
REQ-032 With rst_n=0 at a clk edge: state=IDLE, pos=DEFAULT_POS, auto_o=0, recfg=0, all pulse outputs 0, edge registers 0, timeout counter 0.
REQ-033 Reset in any state SHALL abort the sequence without emitting any further pulse.
REQ-034 A button held high through reset release SHALL NOT produce an edge event.

Configuration
REQ-035 Macro FREQ_SWEEP_AUTO_EN.
- Defined: auto mode SHALL operate as specified.
- Undefined: btn_auto, start_auto, passcount and failcount SHALL be ignored, auto_o SHALL be tied to 0, and REQ-018/019/022 SHALL be absent.

Verification
REQ-036 Reset, then btn_up rising edge, pll_busy=0 -> pos=6; write_from_rom 1 cycle later; reconfig 3 cycles after write_from_rom; recfg low again within 2 cycles of reconfig.
REQ-037 pos=0, btn_up edge -> no pulses, recfg stays 0; pos=10, btn_down edge -> no pulses, recfg stays 0.
REQ-038 Hold pll_busy=1 after the reconfig pulse -> reconfig_reset pulses exactly DONE_TIMEOUT cycles after reconfig; state returns to IDLE.
REQ-039 btn_auto edge, then passcount=5 and failcount=1 held -> pos steps 0,1,...,10 with one reconfiguration each, then stops at 10 with auto_o=1.
REQ-040 start_auto and btn_down edge in the same cycle -> pos=0, auto_o=1; btn_down edge during WAIT_BUSY -> discarded.
REQ-041 rst_n low during WAIT_BUSY -> pos=7 and recfg=0 on the next edge; no reconfig pulse emitted.

Source files
------------

// File: rtl/freq_sweep_ctrl.sv
// Steps a PLL through NUM_STEPS frequency settings by sequencing pll_reconfig.
// The auto-sweep mode is compiled in only when FREQ_SWEEP_AUTO_EN is defined.
module freq_sweep_ctrl #(
    parameter int unsigned NUM_STEPS    = 11,
    parameter int unsigned DEFAULT_POS  = 7,
    parameter int unsigned DONE_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_auto,
    input  logic        start_auto,
    input  logic [31:0] passcount,
    input  logic [31:0] failcount,
    input  logic        pll_busy,
    output logic [3:0]  pos,
    output logic        auto_o,
    output logic        recfg,
    output logic        write_from_rom,
    output logic        reconfig,
    output logic        reconfig_reset
);

    localparam int unsigned     CntW    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [3:0]      LastPos = 4'(NUM_STEPS - 1);
    localparam logic [3:0]      RstPos  = 4'(DEFAULT_POS);
    localparam logic [CntW-1:0] CntLoad = CntW'(DONE_TIMEOUT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      pos_q, pos_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            armed_q;
    logic            up_q, down_q;
    logic            write_q, write_d;
    logic            reconfig_q, reconfig_d;
    logic            rreset_q, rreset_d;
    logic            up_edge, down_edge;
    logic            req;
    logic [3:0]      req_pos;

    // armed_q masks the first cycle after reset so a button held through
    // reset release is not mistaken for a fresh press.
    assign up_edge   = armed_q & btn_up & ~up_q;
    assign down_edge = armed_q & btn_down & ~down_q;

`ifdef FREQ_SWEEP_AUTO_EN
    logic auto_q, auto_d;
    logic bauto_q;
    logic auto_edge;
    logic req_auto;

    assign auto_edge = armed_q & btn_auto & ~bauto_q;
    assign auto_o    = auto_q;
`else
    logic unused_auto_inputs;

    assign unused_auto_inputs = ^{btn_auto, start_auto, passcount, failcount};
    assign auto_o             = 1'b0;
`endif

    // Request decode in priority order; only consumed while idle.
    always_comb begin
        req     = 1'b0;
        req_pos = pos_q;
`ifdef FREQ_SWEEP_AUTO_EN
        req_auto = auto_q;
        if (start_auto) begin
            req      = 1'b1;
            req_pos  = 4'd0;
            req_auto = 1'b1;
        end else if (auto_edge) begin
            req = 1'b1;
            if (!auto_q) begin
                req_pos  = 4'd0;
                req_auto = 1'b1;
            end else begin
                req_auto = 1'b0;
            end
        end else
`endif
        if (up_edge && (pos_q != 4'd0)) begin
            req     = 1'b1;
            req_pos = pos_q - 4'd1;
`ifdef FREQ_SWEEP_AUTO_EN
            req_auto = 1'b0;
`endif
        end else if (down_edge && (pos_q < LastPos)) begin
            req     = 1'b1;
            req_pos = pos_q + 4'd1;
`ifdef FREQ_SWEEP_AUTO_EN
            req_auto = 1'b0;
`endif
        end
`ifdef FREQ_SWEEP_AUTO_EN
        else if (auto_q && (passcount != 32'd0) && (failcount != 32'd0) &&
                 (pos_q < LastPos)) begin
            req     = 1'b1;
            req_pos = pos_q + 4'd1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        first_d    = 1'b0;
        write_d    = 1'b0;
        reconfig_d = 1'b0;
        rreset_d   = 1'b0;
`ifdef FREQ_SWEEP_AUTO_EN
        auto_d = auto_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StLoad;
                    pos_d   = req_pos;
                    write_d = 1'b1;
`ifdef FREQ_SWEEP_AUTO_EN
                    auto_d = req_auto;
`endif
                end
            end
            StLoad:   state_d = StSettle;
            StSettle: state_d = StWaitBusy;
            StWaitBusy: begin
                if (!pll_busy) begin
                    state_d    = StWaitDone;
                    reconfig_d = 1'b1;
                    cnt_d      = CntLoad;
                    first_d    = 1'b1;
                end
            end
            StWaitDone: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end
                // pll_reconfig may not have raised busy yet in the first cycle.
                if (!first_q) begin
                    if (!pll_busy) begin
                        state_d = StIdle;
                    end else if (cnt_q <= CntOne) begin
                        state_d  = StIdle;
                        rreset_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pos_q      <= RstPos;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            armed_q    <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            write_q    <= 1'b0;
            reconfig_q <= 1'b0;
            rreset_q   <= 1'b0;
`ifdef FREQ_SWEEP_AUTO_EN
            auto_q  <= 1'b0;
            bauto_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            armed_q    <= 1'b1;
            up_q       <= btn_up;
            down_q     <= btn_down;
            write_q    <= write_d;
            reconfig_q <= reconfig_d;
            rreset_q   <= rreset_d;
`ifdef FREQ_SWEEP_AUTO_EN
            auto_q  <= auto_d;
            bauto_q <= btn_auto;
`endif
        end
    end

    assign pos            = pos_q;
    assign recfg          = (state_q != StIdle);
    assign write_from_rom = write_q;
    assign reconfig       = reconfig_q;
    assign reconfig_reset = rreset_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl; covers the auto mode when
// FREQ_SWEEP_AUTO_EN is defined and its absence otherwise.
module tb_freq_sweep_ctrl;

    localparam int NSTEPS = 11;
    localparam int DPOS   = 7;
    localparam int TMO    = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_auto = 1'b0, start_auto = 1'b0;
    logic [31:0] passcount = 32'd0, failcount = 32'd0;
    logic        pll_busy = 1'b0;
    logic [3:0]  pos;
    logic        auto_o, recfg, write_from_rom, reconfig, reconfig_reset;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pos   = DPOS;
    bit m_auto  = 1'b0;

    always #5 clk = ~clk;

    freq_sweep_ctrl #(
        .NUM_STEPS   (NSTEPS),
        .DEFAULT_POS (DPOS),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_auto      (btn_auto),
        .start_auto    (start_auto),
        .passcount     (passcount),
        .failcount     (failcount),
        .pll_busy      (pll_busy),
        .pos           (pos),
        .auto_o        (auto_o),
        .recfg         (recfg),
        .write_from_rom(write_from_rom),
        .reconfig      (reconfig),
        .reconfig_reset(reconfig_reset)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: effect of the inputs seen while the controller is idle.
    task automatic model_idle(input bit st, input bit ae, input bit up, input bit dn,
                              input logic [31:0] pc, input logic [31:0] fc, output bit req);
        req = 1'b0;
`ifdef FREQ_SWEEP_AUTO_EN
        if (st) begin
            m_pos = 0; m_auto = 1'b1; req = 1'b1;
        end else if (ae) begin
            if (!m_auto) begin m_pos = 0; m_auto = 1'b1; end
            else m_auto = 1'b0;
            req = 1'b1;
        end else
`endif
        if (up && m_pos > 0) begin
            m_pos = m_pos - 1; m_auto = 1'b0; req = 1'b1;
        end else if (dn && m_pos < NSTEPS - 1) begin
            m_pos = m_pos + 1; m_auto = 1'b0; req = 1'b1;
        end
`ifdef FREQ_SWEEP_AUTO_EN
        else if (m_auto && pc != 0 && fc != 0 && m_pos < NSTEPS - 1) begin
            m_pos = m_pos + 1; req = 1'b1;
        end
`endif
    endtask

    task automatic check_quiet(input string name, input int n);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (write_from_rom || reconfig || reconfig_reset || recfg) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s quiet: activity seen, expected none", name);
        end
    endtask

    // Starts on the write_from_rom cycle; ends on the first idle cycle.
    task automatic run_txn(input string name, input int nb, input int nd, input int inj);
        int r, n_rc, n_rr, n_wr, rr_at, idle_at, budget, exp_r, exp_idle;
        bit moved, tmo;
        logic [3:0] p0;
        r = -1; n_rc = 0; n_rr = 0; n_wr = 0; rr_at = -1; idle_at = -1; moved = 1'b0;
        p0 = pos;
        budget = TMO + 40 + nb;
        for (int i = 0; i < budget; i++) begin
            if (i > 0 && write_from_rom) n_wr++;
            if (reconfig) begin n_rc++; if (r < 0) r = i; end
            if (reconfig_reset) begin n_rr++; rr_at = i; end
            if (pos !== p0) moved = 1'b1;
            if (i > 0 && recfg === 1'b0) begin idle_at = i; break; end
            pll_busy = (r < 0) ? (i < 2 + nb) : (i < r + nd);
            if (inj >= 0) btn_down = (i == inj);
            tick();
        end
        pll_busy = 1'b0;
        btn_down = 1'b0;
        exp_r    = 3 + nb;
        tmo      = (nd >= TMO);
        exp_idle = tmo ? exp_r + TMO : exp_r + 1 + ((nd < 1) ? 1 : nd);
        n_tests++;
        if (r != exp_r || n_rc != 1) begin
            n_fail++;
            $display("FAIL %s reconfig: at=%0d count=%0d expected at=%0d count=1",
                     name, r, n_rc, exp_r);
        end
        n_tests++;
        if (idle_at != exp_idle) begin
            n_fail++;
            $display("FAIL %s idle: at=%0d expected %0d", name, idle_at, exp_idle);
        end
        n_tests++;
        if (n_rr != (tmo ? 1 : 0) || (tmo && rr_at != exp_r + TMO)) begin
            n_fail++;
            $display("FAIL %s reconfig_reset: count=%0d at=%0d expected count=%0d at=%0d",
                     name, n_rr, rr_at, tmo ? 1 : 0, exp_r + TMO);
        end
        n_tests++;
        if (n_wr != 0 || moved) begin
            n_fail++;
            $display("FAIL %s stray: extra writes=%0d pos_moved=%0d expected 0/0",
                     name, n_wr, moved);
        end
    endtask

    task automatic press(input string name, input bit st, input bit ae, input bit up,
                         input bit dn, input int nb, input int nd, input int inj);
        bit req;
        model_idle(st, ae, up, dn, passcount, failcount, req);
        start_auto = st; btn_auto = ae; btn_up = up; btn_down = dn;
        tick();
        start_auto = 1'b0; btn_auto = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        n_tests++;
        if (write_from_rom !== req || recfg !== req) begin
            n_fail++;
            $display("FAIL %s request: write=%b recfg=%b expected %b",
                     name, write_from_rom, recfg, req);
        end
        n_tests++;
        if (pos !== 4'(m_pos) || auto_o !== m_auto) begin
            n_fail++;
            $display("FAIL %s state: pos=%0d auto=%b expected pos=%0d auto=%b",
                     name, pos, auto_o, m_pos, m_auto);
        end
        if (req) run_txn(name, nb, nd, inj);
        else check_quiet(name, 4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pll_busy = 1'($urandom_range(0, 1));
            tick();
        end
        pll_busy = 1'b0;
        n_tests++;
        if (pos !== 4'(DPOS) || auto_o !== 1'b0 || recfg !== 1'b0 ||
            write_from_rom !== 1'b0 || reconfig !== 1'b0 || reconfig_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pos=%0d auto=%b recfg=%b pulses=%b%b%b expected 7,0,0,000",
                     pos, auto_o, recfg, write_from_rom, reconfig, reconfig_reset);
        end
        rst_n = 1'b1;
        m_pos = DPOS;
        m_auto = 1'b0;
        check_quiet("reset_release", 3);
    endtask

    task automatic test_step_up();
        press("step_up", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
        n_tests++;
        if (pos !== 4'd6) begin
            n_fail++;
            $display("FAIL step_up pos: pos=%0d expected 6", pos);
        end
    endtask

    task automatic test_limits();
        while (m_pos > 0)
            press("to_top", 1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 4), -1);
        press("top_limit", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
        while (m_pos < NSTEPS - 1)
            press("to_bottom", 1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 4), -1);
        press("bottom_limit", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, -1);
        n_tests++;
        if (pos !== 4'(NSTEPS - 1)) begin
            n_fail++;
            $display("FAIL bottom_limit pos: pos=%0d expected %0d", pos, NSTEPS - 1);
        end
    endtask

    task automatic test_timeout();
        press("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 2, TMO + 5, -1);
        press("timeout_edge", 1'b0, 1'b0, 1'b1, 1'b0, 0, TMO - 1, -1);
        check_quiet("after_timeout", 3);
    endtask

    task automatic test_priority();
        press("start_vs_down", 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, -1);
        press("down_in_busy", 1'b0, 1'b0, 1'b0, 1'b1, 3, 1, 2);
        check_quiet("discarded_edge", 4);
        n_tests++;
        if (pos !== 4'(m_pos)) begin
            n_fail++;
            $display("FAIL discarded_edge pos: pos=%0d expected %0d", pos, m_pos);
        end
    endtask

`ifdef FREQ_SWEEP_AUTO_EN
    task automatic test_auto_sweep();
        bit req;
        passcount = 32'd0; failcount = 32'd0;
        press("auto_on", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, -1);
        passcount = 32'd5; failcount = 32'd1;
        for (int s = 1; s < NSTEPS; s++) begin
            model_idle(1'b0, 1'b0, 1'b0, 1'b0, passcount, failcount, req);
            tick();
            n_tests++;
            if (write_from_rom !== req || pos !== 4'(m_pos) || auto_o !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep step %0d: write=%b pos=%0d auto=%b expected %b,%0d,1",
                         s, write_from_rom, pos, auto_o, req, m_pos);
            end
            run_txn("sweep", $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end
        check_quiet("sweep_stop", 5);
        n_tests++;
        if (pos !== 4'(NSTEPS - 1) || auto_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_end: pos=%0d auto=%b expected %0d,1", pos, auto_o, NSTEPS - 1);
        end
        passcount = 32'd0; failcount = 32'd0;
        press("auto_off", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    endtask
`else
    task automatic test_auto_disabled();
        passcount = 32'd5; failcount = 32'd1;
        press("auto_btn_ignored", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
        press("start_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, -1);
        n_tests++;
        if (auto_o !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_tied: auto=%b expected 0", auto_o);
        end
        passcount = 32'd0; failcount = 32'd0;
    endtask
`endif

    task automatic test_reset_abort();
        bit req;
        if (m_pos == NSTEPS - 1) begin
            model_idle(1'b0, 1'b0, 1'b1, 1'b0, passcount, failcount, req);
            btn_up = 1'b1;
        end else begin
            model_idle(1'b0, 1'b0, 1'b0, 1'b1, passcount, failcount, req);
            btn_down = 1'b1;
        end
        tick();
        btn_up = 1'b0; btn_down = 1'b0;
        pll_busy = 1'b1;
        n_tests++;
        if (write_from_rom !== 1'b1 || pos !== 4'(m_pos)) begin
            n_fail++;
            $display("FAIL abort_start: write=%b pos=%0d expected 1,%0d", write_from_rom, pos, m_pos);
        end
        tick(); tick(); tick();
        // Dropping busy together with reset would fire reconfig if reset were ignored.
        rst_n = 1'b0; pll_busy = 1'b0; btn_up = 1'b1;
        tick();
        n_tests++;
        if (pos !== 4'(DPOS) || recfg !== 1'b0 || reconfig !== 1'b0 || reconfig_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: pos=%0d recfg=%b reconfig=%b rreset=%b expected 7,0,0,0",
                     pos, recfg, reconfig, reconfig_reset);
        end
        tick();
        rst_n = 1'b1;
        m_pos = DPOS;
        m_auto = 1'b0;
        check_quiet("held_through_reset", 6);
        btn_up = 1'b0;
        tick();
        n_tests++;
        if (pos !== 4'(DPOS) || auto_o !== 1'b0) begin
            n_fail++;
            $display("FAIL held_through_reset pos: pos=%0d auto=%b expected 7,0", pos, auto_o);
        end
    endtask

    task automatic test_random();
        bit st, ae, up, dn;
        for (int k = 0; k < 40; k++) begin
            st = ($urandom_range(0, 7) == 0);
            ae = ($urandom_range(0, 4) == 0);
            up = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            passcount = $urandom;
            failcount = $urandom;
            if ($urandom_range(0, 1) == 0) passcount = 32'd0;
            else failcount = 32'd0;
            press("random", st, ae, up, dn, $urandom_range(0, 4), $urandom_range(0, 6), -1);
        end
        passcount = 32'd0; failcount = 32'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_step_up();
        test_limits();
        test_timeout();
        test_priority();
`ifdef FREQ_SWEEP_AUTO_EN
        test_auto_sweep();
`else
        test_auto_disabled();
`endif
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
